// File: rtl/aclk_alarm_sequencer.sv
// Alarm sequencer: compares current and alarm BCD time and runs the ring/snooze/hold lifecycle.
// Snooze support is compiled in only when the ACLK_SNOOZE_EN macro is defined.
module aclk_alarm_sequencer #(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_SECONDS = 300,
  parameter int MAX_SNOOZE     = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_second,
  input  logic [3:0] cur_ms_hr,
  input  logic [3:0] cur_ls_hr,
  input  logic [3:0] cur_ms_min,
  input  logic [3:0] cur_ls_min,
  input  logic [3:0] alm_ms_hr,
  input  logic [3:0] alm_ls_hr,
  input  logic [3:0] alm_ms_min,
  input  logic [3:0] alm_ls_min,
  input  logic       alarm_enable,
  input  logic       stop_alarm,
  input  logic       snooze_button,
  input  logic       load_new_a,
  output logic       sound_alarm,
  output logic       snooze_active,
  output logic [2:0] snooze_left,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [8:0] RING_LAST   = 9'(RING_SECONDS - 1);
  localparam logic [8:0] SNOOZE_LAST = 9'(SNOOZE_SECONDS - 1);

  state_t     state;
  state_t     state_n;
  logic [8:0] timer;
  logic [8:0] timer_n;
  logic       match;
  logic       match_d;
  logic       match_rise;
  logic       quit;

`ifdef ACLK_SNOOZE_EN
  localparam logic [2:0] MAX_S = 3'(MAX_SNOOZE);
  logic [2:0] snz_cnt;
  logic [2:0] snz_cnt_n;
`else
  logic unused_snooze;
  assign unused_snooze = snooze_button | (MAX_SNOOZE < 0);
`endif

  assign match = (cur_ms_hr == alm_ms_hr) && (cur_ls_hr == alm_ls_hr) &&
                 (cur_ms_min == alm_ms_min) && (cur_ls_min == alm_ls_min);
  assign match_rise = match & ~match_d;
  assign quit       = ~alarm_enable | stop_alarm;
  assign state_dbg  = state;

  // Next-state logic; load_new_a overrides everything else.
  always_comb begin
    state_n = state;
`ifdef ACLK_SNOOZE_EN
    snz_cnt_n = snz_cnt;
`endif
    if (load_new_a) begin
      state_n = HOLD;
    end else begin
      unique case (state)
        IDLE: begin
          if (alarm_enable && match_rise) begin
            state_n = RING;
`ifdef ACLK_SNOOZE_EN
            snz_cnt_n = '0;
`endif
          end
        end
        RING: begin
          if (quit) begin
            state_n = HOLD;
`ifdef ACLK_SNOOZE_EN
          end else if (snooze_button && (snz_cnt < MAX_S)) begin
            state_n   = SNOOZE;
            snz_cnt_n = snz_cnt + 3'd1;
`endif
          end else if (one_second && (timer == RING_LAST)) begin
            state_n = HOLD;
          end
        end
        SNOOZE: begin
          if (quit) begin
            state_n = HOLD;
          end else if (one_second && (timer == SNOOZE_LAST)) begin
            state_n = RING;
          end
        end
        HOLD: begin
          if (!match) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end

    // The timer restarts on every state change so each phase counts from zero.
    if (state_n != state) begin
      timer_n = '0;
    end else if (one_second && ((state == RING) || (state == SNOOZE))) begin
      timer_n = timer + 9'd1;
    end else begin
      timer_n = timer;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      timer         <= '0;
      match_d       <= 1'b1;
      sound_alarm   <= 1'b0;
      snooze_active <= 1'b0;
`ifdef ACLK_SNOOZE_EN
      snz_cnt       <= '0;
      snooze_left   <= MAX_S;
`else
      snooze_left   <= '0;
`endif
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      match_d     <= match;
      sound_alarm <= (state_n == RING);
`ifdef ACLK_SNOOZE_EN
      snooze_active <= (state_n == SNOOZE);
      snz_cnt       <= snz_cnt_n;
      snooze_left   <= MAX_S - snz_cnt_n;
`else
      snooze_active <= 1'b0;
      snooze_left   <= '0;
`endif
    end
  end

endmodule
